// File: rtl/io_bus_controller.sv
// MIPS IO bus controller: decodes data memory, keyboard and screen regions.
// Define IO_KBD_FIFO_EN for a 4-entry keyboard FIFO (default: 1-entry register).
module io_bus_controller #(
  parameter int unsigned SCR_TIMEOUT = 255,
  parameter logic [31:0] KBD_BASE    = 32'h1000_0000,
  parameter logic [31:0] SCR_BASE    = 32'h2000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [1:0]  unit_select,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_we,
  output logic        scr_we,
  output logic [11:0] scr_addr,
  output logic [31:0] scr_wdata,
  input  logic        scr_ready,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_code
);

`ifdef IO_KBD_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(SCR_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCR_TIMEOUT - 1);
  localparam logic [2:0]    FULL_CNT = 3'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  typedef enum logic {IDLE, SCR_WAIT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [11:0]   scr_addr_q, scr_addr_d;
  logic [31:0]   scr_wdata_q, scr_wdata_d;
  logic          scr_to_q, scr_to_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic kbd_sel, scr_sel, rd_en, wr_en, st_wait, act;
  logic pop, push, full, ovf_set, stat_rd;
  logic scr_wr_req, to_rd;
  logic [31:0] kbd_rdata;
  logic unused_bits;

  assign kbd_sel = cpu_addr[31:28] == KBD_BASE[31:28];
  assign scr_sel = ~kbd_sel & (cpu_addr[31:28] == SCR_BASE[31:28]);
  assign wr_en   = cpu_wr;
  assign rd_en   = cpu_rd & ~cpu_wr;
  assign st_wait = state_q == SCR_WAIT;
  assign act     = ~st_wait & ~reset;
  assign unused_bits = ^{cpu_addr[27:14], cpu_addr[1:0]};

  assign full    = cnt_q == FULL_CNT;
  assign pop     = act & kbd_sel & rd_en & (cpu_addr[3:2] == 2'b00)
                 & (cnt_q != 3'd0);
  assign push    = kbd_valid & (~full | pop);
  assign ovf_set = kbd_valid & full & ~pop;
  assign stat_rd = act & kbd_sel & rd_en & (cpu_addr[3:2] == 2'b01);

  assign scr_wr_req = act & scr_sel & wr_en;
  assign to_rd      = act & scr_sel & rd_en;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + 3'(push) - 3'(pop);
    ovf_d    = ovf_q;
    if (push) begin
      mem_d[wr_ptr_q] = kbd_code;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    end
    // A fresh overflow wins over the clear from a status read.
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (stat_rd) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    scr_addr_d  = scr_addr_q;
    scr_wdata_d = scr_wdata_q;
    scr_to_d    = scr_to_q;
    if (to_rd) begin
      scr_to_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (scr_wr_req & ~scr_ready) begin
          state_d     = SCR_WAIT;
          wait_cnt_d  = '0;
          scr_addr_d  = cpu_addr[13:2];
          scr_wdata_d = cpu_wdata;
        end
      end
      SCR_WAIT: begin
        wait_cnt_d = wait_cnt_q + CW'(1);
        if (scr_ready) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
          scr_to_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      scr_addr_q  <= '0;
      scr_wdata_q <= '0;
      scr_to_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      scr_addr_q  <= scr_addr_d;
      scr_wdata_q <= scr_wdata_d;
      scr_to_q    <= scr_to_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      mem_q       <= mem_d;
    end
  end

  always_comb begin
    kbd_rdata = 32'h0;
    case (cpu_addr[3:2])
      2'b00: begin
        if (cnt_q != 3'd0) begin
          kbd_rdata = {23'b0, 1'b1, mem_q[rd_ptr_q]};
        end
      end
      2'b01:   kbd_rdata = {23'b0, ovf_q, 5'b0, cnt_q};
      default: kbd_rdata = 32'h0;
    endcase
  end

  always_comb begin
    cpu_rdata = dmem_rdata;
    unique case (1'b1)
      kbd_sel: cpu_rdata = kbd_rdata;
      scr_sel: cpu_rdata = {31'b0, scr_to_q};
      default: cpu_rdata = dmem_rdata;
    endcase
  end

  always_comb begin
    unit_select = 2'b00;
    unique case (1'b1)
      (~st_wait & kbd_sel): unit_select = 2'b01;
      (st_wait | scr_sel):  unit_select = 2'b10;
      default:              unit_select = 2'b00;
    endcase
  end

  assign dmem_we   = act & wr_en & ~kbd_sel & ~scr_sel;
  assign cpu_stall = ~reset & st_wait;
  assign scr_we    = ~reset & (st_wait | scr_wr_req);
  assign scr_addr  = st_wait ? scr_addr_q : cpu_addr[13:2];
  assign scr_wdata = st_wait ? scr_wdata_q : cpu_wdata;

endmodule

// File: tb/tb_io_bus_controller.sv
// Directed scoreboard bench for io_bus_controller (SCR_TIMEOUT=4).
module tb_io_bus_controller;

`ifdef IO_KBD_FIFO_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif

  localparam logic [31:0] KD = 32'h1000_0000;
  localparam logic [31:0] KS = 32'h1000_0004;
  localparam logic [31:0] SA = 32'h2000_0010;
  localparam logic [31:0] DM = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dmem_rdata, scr_wdata;
  logic        cpu_rd, cpu_wr, cpu_stall, dmem_we, scr_we, scr_ready;
  logic [1:0]  unit_select;
  logic [11:0] scr_addr;
  logic        kbd_valid;
  logic [7:0]  kbd_code;

  int total = 0;
  int bad = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  io_bus_controller #(.SCR_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .unit_select(unit_select),
    .dmem_rdata(dmem_rdata), .dmem_we(dmem_we),
    .scr_we(scr_we), .scr_addr(scr_addr),
    .scr_wdata(scr_wdata), .scr_ready(scr_ready),
    .kbd_valid(kbd_valid), .kbd_code(kbd_code)
  );

  task automatic ex(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] wd,
                     input logic rd, input logic wr);
    cpu_addr = a;
    cpu_wdata = wd;
    cpu_rd = rd;
    cpu_wr = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_code(input logic [7:0] c);
    bus(DM, 32'h0, 1'b0, 1'b0);
    kbd_valid = 1'b1;
    kbd_code = c;
    tick();
    kbd_valid = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a,
                        input logic [31:0] e);
    bus(a, 32'h0, 1'b1, 1'b0);
    ex(e);
    #3;
    chk(tag, cpu_rdata);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    scr_ready = 1'b0;
    kbd_valid = 1'b0;
    kbd_code = 8'h0;
    dmem_rdata = 32'h0;
    bus(SA, 32'h1111_2222, 1'b0, 1'b1);
    #3;
    ex(32'h0); chk("rst_stall", {31'b0, cpu_stall});
    ex(32'h0); chk("rst_scr_we", {31'b0, scr_we});
    tick();
    bus(32'h40, 32'h5, 1'b0, 1'b1);
    #3;
    ex(32'h0); chk("rst_dmem_we", {31'b0, dmem_we});
    tick();

    reset = 1'b0;
    bus(KS, 32'h0, 1'b1, 1'b0);
    ex(32'h0);
    ex(32'h1);
    #3;
    chk("rst_status", cpu_rdata);
    chk("kbd_unit", {30'b0, unit_select});
    tick();

    bus(32'h40, 32'h0, 1'b1, 1'b0);
    dmem_rdata = 32'h1234_5678;
    ex(32'h1234_5678); ex(32'h0); ex(32'h0);
    #3;
    chk("dmem_rdata", cpu_rdata);
    chk("dmem_unit", {30'b0, unit_select});
    chk("dmem_stall", {31'b0, cpu_stall});
    bus(32'h40, 32'hCAFE, 1'b1, 1'b1);
    ex(32'h1); ex(32'h0);
    #1;
    chk("dmem_we_rdwr", {31'b0, dmem_we});
    chk("dmem_scr_we", {31'b0, scr_we});
    tick();

    push_code(8'h1C);
    push_code(8'h32);
    rd_chk("two_status", KS, (D == 4) ? 32'h0000_0002 : 32'h0000_0101);
    rd_chk("data_1c", KD, 32'h0000_011C);
    rd_chk("data_32", KD, (D == 4) ? 32'h0000_0132 : 32'h0);
    rd_chk("data_empty", KD, 32'h0);

    push_code(8'h55);
    bus(KD, 32'hFFFF_FFFF, 1'b1, 1'b1);
    tick();
    rd_chk("kwr_status", KS, 32'h0000_0001);
    rd_chk("kwr_data", KD, 32'h0000_0155);

    for (int i = 0; i < 5; i++) begin
      push_code(8'hA0 + 8'(i));
    end
    rd_chk("ovf_status", KS, (D == 4) ? 32'h0000_0104 : 32'h0000_0101);
    rd_chk("ovf_clear", KS, (D == 4) ? 32'h0000_0004 : 32'h0000_0001);
    for (int i = 0; i < D; i++) begin
      rd_chk("drain_a", KD, {23'b0, 1'b1, 8'hA0 + 8'(i)});
    end
    rd_chk("drain_a_empty", KD, 32'h0);

    kbd_valid = 1'b1;
    kbd_code = 8'h77;
    rd_chk("pushpop_empty", KD, 32'h0);
    kbd_valid = 1'b0;
    rd_chk("pp_empty_stat", KS, 32'h0000_0001);
    rd_chk("pp_empty_data", KD, 32'h0000_0177);

    for (int i = 0; i < D; i++) begin
      push_code(8'hB0 + 8'(i));
    end
    kbd_valid = 1'b1;
    kbd_code = 8'hC0;
    rd_chk("pushpop_full", KD, 32'h0000_01B0);
    kbd_valid = 1'b0;
    rd_chk("pp_full_stat", KS, 32'(D));
    for (int i = 1; i < D; i++) begin
      rd_chk("drain_b", KD, {23'b0, 1'b1, 8'hB0 + 8'(i)});
    end
    rd_chk("drain_c0", KD, 32'h0000_01C0);
    rd_chk("drain_b_empty", KD, 32'h0);

    bus(SA, 32'hDEAD_BEEF, 1'b0, 1'b1);
    scr_ready = 1'b0;
    ex(32'h1); ex(32'h0); ex(32'h2); ex(32'h004);
    #3;
    chk("st_scr_we", {31'b0, scr_we});
    chk("st_stall0", {31'b0, cpu_stall});
    chk("st_unit", {30'b0, unit_select});
    chk("st_addr", {20'b0, scr_addr});
    tick();
    bus(32'h80, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      ex(32'h1); ex(32'h1); ex(32'h004); ex(32'hDEAD_BEEF); ex(32'h2);
      #3;
      chk("wait_stall", {31'b0, cpu_stall});
      chk("wait_scr_we", {31'b0, scr_we});
      chk("wait_addr", {20'b0, scr_addr});
      chk("wait_wdata", scr_wdata);
      chk("wait_unit", {30'b0, unit_select});
      tick();
    end
    scr_ready = 1'b1;
    ex(32'h1);
    #3;
    chk("ready_stall", {31'b0, cpu_stall});
    tick();
    scr_ready = 1'b0;
    ex(32'h0); ex(32'h0);
    #3;
    chk("done_stall", {31'b0, cpu_stall});
    chk("done_scr_we", {31'b0, scr_we});
    tick();
    rd_chk("no_timeout", SA, 32'h0);

    bus(32'h2000_0020, 32'h1234, 1'b0, 1'b1);
    ex(32'h0);
    #3;
    chk("to_stall0", {31'b0, cpu_stall});
    tick();
    bus(DM, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ex(32'h1);
      #3;
      chk("to_stall", {31'b0, cpu_stall});
      tick();
    end
    ex(32'h0);
    #3;
    chk("to_release", {31'b0, cpu_stall});
    tick();
    rd_chk("to_flag", SA, 32'h1);
    rd_chk("to_cleared", SA, 32'h0);

    bus(SA, 32'h0000_0042, 1'b0, 1'b1);
    scr_ready = 1'b1;
    ex(32'h1); ex(32'h0);
    #3;
    chk("rdy_scr_we", {31'b0, scr_we});
    chk("rdy_stall", {31'b0, cpu_stall});
    tick();
    bus(DM, 32'h0, 1'b0, 1'b0);
    ex(32'h0);
    #3;
    chk("rdy_after", {31'b0, cpu_stall});
    tick();
    scr_ready = 1'b0;

    bus(SA, 32'h0000_0099, 1'b0, 1'b1);
    tick();
    bus(DM, 32'h0, 1'b0, 1'b0);
    ex(32'h1);
    #3;
    chk("abort_pre", {31'b0, cpu_stall});
    tick();
    reset = 1'b1;
    ex(32'h0); ex(32'h0);
    #3;
    chk("abort_rst_stall", {31'b0, cpu_stall});
    chk("abort_rst_we", {31'b0, scr_we});
    tick();
    reset = 1'b0;
    ex(32'h0); ex(32'h0);
    #3;
    chk("abort_stall", {31'b0, cpu_stall});
    chk("abort_scr_we", {31'b0, scr_we});
    tick();
    rd_chk("abort_no_to", SA, 32'h0);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL sb_leftover: observed %0d expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
